// File: rtl/serial_pkg.sv
// serial_pkg: state encoding and counter sizing shared by both ends of the serial link
package serial_pkg;
  typedef enum logic {IDLE, SHIFT} state_t;
  function automatic int cnt_width(input int w);
    return (w > 2) ? $clog2(w) : 1;
  endfunction
endpackage

// File: rtl/bit_serializer.sv
// bit_serializer: accepts a word over valid/ready and shifts it out one registered bit per clock
module bit_serializer
  import serial_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             rst_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             valid_i,
  output logic             ready_o,
  output logic             bit_o,
  output logic             bit_valid_o,
  output logic             last_o
);
  localparam int CW = cnt_width(WIDTH);
  localparam logic [CW-1:0] TOP = CW'(WIDTH - 1);
  state_t state, state_d;
  logic [WIDTH-1:0] sreg, sreg_d;
  logic [CW-1:0] cnt, cnt_d;
  logic bit_d, load, done;
  function automatic logic head(input logic [WIDTH-1:0] w);
    return MSB_FIRST ? w[WIDTH-1] : w[0];
  endfunction
  function automatic logic [WIDTH-1:0] adv(input logic [WIDTH-1:0] w);
    return MSB_FIRST ? w << 1 : w >> 1;
  endfunction
  assign done = (state == SHIFT) && (cnt == '0);
  assign ready_o = (state == IDLE) || done;
  assign load = valid_i && ready_o;
  assign bit_valid_o = state == SHIFT;
  assign last_o = done;
  // the loaded word's head goes straight to bit_o, so the register holds what follows it
  always_comb begin
    state_d = load ? SHIFT : done ? IDLE : state;
    sreg_d = load ? adv(data_i) : (state == SHIFT) ? adv(sreg) : sreg;
    cnt_d = load ? TOP : (state == SHIFT && !done) ? cnt - CW'(1) : cnt;
    bit_d = load ? head(data_i) : (state == SHIFT && !done) ? head(sreg) : 1'b0;
  end
  always_ff @(posedge clk) begin
    if (rst_i) begin
      state <= IDLE;
      sreg <= '0;
      cnt <= '0;
      bit_o <= 1'b0;
    end else begin
      state <= state_d;
      sreg <= sreg_d;
      cnt <= cnt_d;
      bit_o <= bit_d;
    end
  end
`ifdef FORMAL
  am_data: assume property (@(posedge clk) (valid_i && !ready_o) |=> (!valid_i || $stable(data_i)));
  ap_load: assert property (@(posedge clk) disable iff (rst_i) load |=> bit_valid_o);
  ap_bit: assert property (@(posedge clk) disable iff (rst_i)
    (state == SHIFT && !done) |=> (bit_valid_o && bit_o == $past(head(sreg))));
  ap_rst: assert property (@(posedge clk) rst_i |=> (!bit_valid_o && !bit_o && ready_o && !last_o));
  cv_b2b: cover property (@(posedge clk) disable iff (rst_i) (done && valid_i) ##1 bit_valid_o);
`endif
endmodule

// File: tb/tb_bit_serializer.sv
// tb_bit_serializer: three serializer instances checked against a bit-queue model of the stream
module tb_bit_serializer;
  logic clk = 1'b0;
  logic rst;
  logic [7:0] dm, dl;
  logic [0:0] d1;
  logic vm, vl, v1;
  logic rm, bm, bvm, lm, rl, bl, bvl, ll, r1, b1, bv1, l1;
  int errs = 0, checks = 0;
  bit qm[$], ql[$], q1[$];
  logic [15:0] capm;
  logic [7:0] capl;
  logic [2:0] cap1;
  always #5 clk = ~clk;
  bit_serializer #(.WIDTH(8), .MSB_FIRST(1'b1)) u_m (.clk(clk), .rst_i(rst), .data_i(dm), .valid_i(vm),
    .ready_o(rm), .bit_o(bm), .bit_valid_o(bvm), .last_o(lm));
  bit_serializer #(.WIDTH(8), .MSB_FIRST(1'b0)) u_l (.clk(clk), .rst_i(rst), .data_i(dl), .valid_i(vl),
    .ready_o(rl), .bit_o(bl), .bit_valid_o(bvl), .last_o(ll));
  bit_serializer #(.WIDTH(1), .MSB_FIRST(1'b1)) u_1 (.clk(clk), .rst_i(rst), .data_i(d1), .valid_i(v1),
    .ready_o(r1), .bit_o(b1), .bit_valid_o(bv1), .last_o(l1));
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  // the queue holds every bit still to appear on bit_o; its front is the bit on the wire now
  task automatic model(ref bit q[$], input int w, input bit msb, input logic v, input logic [31:0] d, input logic r);
    bit rdy;
    rdy = q.size() <= 1;
    if (r) q.delete();
    else begin
      if (q.size() > 0) q.delete(0);
      if (v && rdy) for (int i = 0; i < w; i++) q.push_back(msb ? d[w-1-i] : d[i]);
    end
  endtask
  task automatic check(input string n, input bit q[$], input logic r, input logic bv, input logic b, input logic l);
    chk({n, ".ready"}, 32'(r), 32'(q.size() <= 1));
    chk({n, ".bit_valid"}, 32'(bv), 32'(q.size() > 0));
    chk({n, ".bit"}, 32'(b), q.size() > 0 ? 32'(q[0]) : 32'd0);
    chk({n, ".last"}, 32'(l), 32'(q.size() == 1));
  endtask
  task automatic tick;
    @(negedge clk);
    check("m8", qm, rm, bvm, bm, lm);
    check("l8", ql, rl, bvl, bl, ll);
    check("w1", q1, r1, bv1, b1, l1);
    if (bvm === 1'b1) capm = {capm[14:0], bm};
    if (bvl === 1'b1) capl = {bl, capl[7:1]};
    if (bv1 === 1'b1) cap1 = {cap1[1:0], b1};
    @(posedge clk);
    model(qm, 8, 1'b1, vm, 32'(dm), rst);
    model(ql, 8, 1'b0, vl, 32'(dl), rst);
    model(q1, 1, 1'b1, v1, 32'(d1), rst);
    #1;
  endtask
  initial begin
    rst = 1'b1; vm = 1'b0; vl = 1'b0; v1 = 1'b0; dm = '0; dl = '0; d1 = '0;
    capm = '0; capl = '0; cap1 = '0;
    @(posedge clk); #1;
    tick;
    rst = 1'b0;
    tick;
    dm = 8'hA5; vm = 1'b1; tick; vm = 1'b0;
    repeat (9) tick;
    chk("a5_word", 32'(capm[7:0]), 32'h0000_00A5);
    dl = 8'h01; vl = 1'b1; tick; vl = 1'b0;
    repeat (9) tick;
    chk("lsb_word", 32'(capl), 32'h0000_0001);
    capm = '0;
    dm = 8'hFF; vm = 1'b1; tick;
    dm = 8'h00; repeat (8) tick;
    vm = 1'b0; repeat (9) tick;
    chk("b2b_words", 32'(capm), 32'h0000_FF00);
    dm = 8'hAA; vm = 1'b1; tick; vm = 1'b0;
    repeat (3) tick;
    dm = 8'h3C; vm = 1'b1; repeat (5) tick;
    vm = 1'b0; repeat (9) tick;
    chk("backpressure", 32'(capm), 32'h0000_AA3C);
    dm = 8'hF0; vm = 1'b1; tick; vm = 1'b0;
    repeat (4) tick;
    rst = 1'b1; tick; rst = 1'b0;
    tick;
    capm = '0;
    dm = 8'h81; vm = 1'b1; tick; vm = 1'b0;
    repeat (9) tick;
    chk("after_reset", 32'(capm[7:0]), 32'h0000_0081);
    v1 = 1'b1; d1 = 1'b1; tick;
    d1 = 1'b0; tick;
    d1 = 1'b1; tick;
    v1 = 1'b0; repeat (2) tick;
    chk("w1_stream", 32'(cap1), 32'h0000_0005);
    repeat (600) begin
      rst = ($urandom_range(63) == 0);
      if (!(vm && qm.size() > 1)) dm = 8'($urandom);
      if (!(vl && ql.size() > 1)) dl = 8'($urandom);
      if (!(v1 && q1.size() > 1)) d1 = 1'($urandom);
      vm = 1'($urandom_range(3) != 0);
      vl = 1'($urandom_range(1));
      v1 = 1'($urandom_range(1));
      tick;
    end
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule

// File: doc/bit_serializer.md
# bit_serializer

Parallel-to-serial transmitter that drives a one-bit-per-cycle stream. Its output is sampled by a downstream single-flop capture stage. It accepts a WIDTH-bit word over a valid/ready handshake and shifts the word out on `bit_o`, one bit per clock. It supports back-to-back words with no idle cycle between them. It sits between a word-oriented producer and the serial link.

## Interface

Parameters:

- `WIDTH`, default 8: word width in bits; legal range 1..32.
- `MSB_FIRST`, default 1: 1 sends bit WIDTH-1 first; 0 sends bit 0 first.

Ports:

- `clk`  input  1  clock; all logic on the rising edge.
- `rst_i`  input  1  reset; synchronous and active-high.
- `data_i`  input  WIDTH  word to transmit; sampled on the handshake cycle.
- `valid_i`  input  1  producer has a word on `data_i`.
- `ready_o`  output  1  block can accept a word this cycle.
- `bit_o`  output  1  serial data bit (registered).
- `bit_valid_o`  output  1  `bit_o` carries a word bit this cycle.
- `last_o`  output  1  `bit_o` is the final bit of the current word.

## Operation

- States are IDLE and SHIFT.
- A handshake occurs when `valid_i && ready_o` at a rising edge.
- IDLE:
  - `ready_o`=1 and `bit_valid_o`=0.
  - On handshake: load the shift register with `data_i`, set the bit counter to WIDTH-1, and go to SHIFT.
- SHIFT:
  - Each cycle, present the current head bit on `bit_o`, shift the register by one, and decrement the counter.
  - `last_o`=1 when the counter is 0.
- End of word (counter 0):
  - `ready_o`=1 during the last-bit cycle.
  - If a handshake occurs in that cycle, reload and stay in SHIFT. The next word's first bit follows in the next cycle with zero bubble.
  - Otherwise, return to IDLE.
- Outside the last-bit cycle, SHIFT holds `ready_o`=0.
- `ready_o` is a combinational function of state and counter only. It never depends on `valid_i`.
- Bit ordering:
  - MSB_FIRST=1: shift left, head = bit WIDTH-1.
  - MSB_FIRST=0: shift right, head = bit 0.
- Counter width: max(1, $clog2(WIDTH)).
- WIDTH=1: every SHIFT cycle is the last-bit cycle. `ready_o` stays high, and a continuous `valid_i` gives one word per cycle.
- When `bit_valid_o`=0, `bit_o` is driven 0 (never X).
- The producer must hold `data_i` stable while `valid_i`=1 and `ready_o`=0. The block does not sample `data_i` in those cycles.
- `valid_i` deasserting without a handshake is legal and has no effect.

## Timing

- Reset values: state IDLE, `ready_o`=1, `bit_o`=0, `bit_valid_o`=0, `last_o`=0, counter 0, shift register 0.
- Reset has priority over everything, including a handshake in the same cycle.
- Reset mid-word discards the remaining bits. The cycle after reset shows the reset values.
- Latency: if the handshake is at edge N, the first bit appears on `bit_o` with `bit_valid_o`=1 in cycle N+1.
- Word duration: exactly WIDTH consecutive cycles of `bit_valid_o`=1.
- Throughput: one word per WIDTH cycles with `valid_i` held high.
- Formal property: in SHIFT, `bit_o` equals `$past` of the shift-register head.
- Formal property: `bit_valid_o` never drops mid-word except on reset.

## Structure

- Shared package `serial_pkg` holds:
  - the state enum (IDLE, SHIFT);
  - the counter-width constant function, shared with the receiver side of the link.
- No sub-module. The shift register, counter and two-state FSM live in one module.
- An `ifdef FORMAL` section carries the handshake and stream assertions listed under Timing, plus:
  - an assume for stable `data_i` under back-pressure;
  - a cover for back-to-back words.

## Test plan

- Reset then a single word: WIDTH=8, MSB_FIRST=1, `data_i`=8'hA5 handshaken at cycle 2.
  - Cycles 3..10: `bit_o` = 1,0,1,0,0,1,0,1.
  - `last_o`=1 only at cycle 10; `ready_o`=1 only at cycle 10; IDLE at cycle 11.
- LSB-first: MSB_FIRST=0, `data_i`=8'h01.
  - First `bit_o`=1, then seven 0s.
- Back-to-back: 8'hFF then 8'h00 with `valid_i` held high.
  - 16 contiguous cycles of `bit_valid_o`=1: eight 1s then eight 0s.
  - The second handshake lands on the last-bit cycle of the first word.
- Back-pressure: assert `valid_i` with 8'h3C mid-word.
  - No handshake until the last-bit cycle; 8'h3C is then sent intact.
- Reset mid-word: assert `rst_i` at bit 4 of 8'hF0.
  - Next cycle: `bit_valid_o`=0, `bit_o`=0, `ready_o`=1.
  - A new word 8'h81 is then sent correctly.
- WIDTH=1 instance with `valid_i` high and `data_i` toggling 1,0,1.
  - `bit_o` = 1,0,1 on consecutive cycles; `last_o` and `ready_o` remain 1 throughout.
